// File: rtl/icf3z_intc_pkg.sv
// Shared definitions for the icf3z interrupt controller: register offsets,
// VEC field positions, default port base and the priority-result payload.
package icf3z_intc_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned IDX_W  = 3;

    localparam logic [DATA_W-1:0] DEFAULT_BASE = 8'hE0;

    localparam logic [IDX_W-1:0] OFS_PEND  = 3'd0;
    localparam logic [IDX_W-1:0] OFS_MASK  = 3'd1;
    localparam logic [IDX_W-1:0] OFS_ROUTE = 3'd2;
    localparam logic [IDX_W-1:0] OFS_EDGE  = 3'd3;
    localparam logic [IDX_W-1:0] OFS_VEC   = 3'd4;
    localparam logic [IDX_W-1:0] OFS_SWSET = 3'd5;

    localparam int unsigned VEC_VALID = 7;
    localparam int unsigned VEC_GRP   = 6;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } prio_t;

    // Pack a priority result into the VEC register layout {valid, grp, 000, idx}.
    function automatic logic [DATA_W-1:0] make_vec(input prio_t p, input logic grp);
        logic [DATA_W-1:0] v;
        v = '0;
        if (p.valid) begin
            v[VEC_VALID]   = 1'b1;
            v[VEC_GRP]     = grp;
            v[IDX_W-1:0]   = p.idx;
        end
        return v;
    endfunction

endpackage

// File: rtl/icf3z_intc_prio.sv
// Lowest-index-wins priority encoder over one 8-bit request group.
module icf3z_intc_prio
    import icf3z_intc_pkg::*;
(
    input  logic [DATA_W-1:0] req,
    output prio_t             res_c
);

    // Scan high to low so the lowest set index is the last one written.
    always_comb begin
        res_c = '0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            if (req[i]) begin
                res_c.valid = 1'b1;
                res_c.idx   = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/icf3z_intc.sv
// icf3z interrupt controller: pending/mask/route/edge registers on the CPU port bus.
// Optional macro ICF3Z_INTC_SYNC_EN adds a 2-flop synchronizer on every source.
module icf3z_intc
    import icf3z_intc_pkg::*;
#(
    parameter logic [DATA_W-1:0] BASE = DEFAULT_BASE,
    parameter int unsigned       NSRC = 8
) (
    input  logic              CLK,
    input  logic              xRESET_P,
    input  logic [NSRC-1:0]   xSRC_P,
    input  logic [DATA_W-1:0] xPORTID_P,
    input  logic [DATA_W-1:0] xOUTPORT_P,
    input  logic              xWSTROBE_P,
    input  logic              xRSTROBE_P,
    output logic [DATA_W-1:0] xRDATA_P,
    output logic              xHIT_P,
    output logic              xINT0_P,
    output logic              xINT1_P
);

    // Bits above NSRC are held at zero everywhere so they read 0 and never pend.
    localparam logic [DATA_W-1:0] SRC_MASK = DATA_W'((16'd1 << NSRC) - 16'd1);

    logic [NSRC-1:0]   src_s;
    logic [DATA_W-1:0] src;

`ifdef ICF3Z_INTC_SYNC_EN
    logic [NSRC-1:0] sync_q1;
    logic [NSRC-1:0] sync_q2;

    always_ff @(posedge CLK) begin
        if (xRESET_P) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= xSRC_P;
            sync_q2 <= sync_q1;
        end
    end

    assign src_s = sync_q2;
`else
    assign src_s = xSRC_P;
`endif

    assign src = DATA_W'(src_s);

    logic [DATA_W-1:0] pend_q;
    logic [DATA_W-1:0] mask_q;
    logic [DATA_W-1:0] route_q;
    logic [DATA_W-1:0] edge_q;
    logic [DATA_W-1:0] prev_q;

    // Address decode: the block owns the 8-aligned window starting at BASE.
    logic             in_range;
    logic [IDX_W-1:0] ofs;
    logic             wr_en;
    logic             vec_rd;

    assign in_range = (xPORTID_P[DATA_W-1:IDX_W] == BASE[DATA_W-1:IDX_W]);
    assign ofs      = xPORTID_P[IDX_W-1:0];
    assign wr_en    = xWSTROBE_P & in_range;
    assign vec_rd   = xRSTROBE_P & in_range & (ofs == OFS_VEC);

    logic [DATA_W-1:0] act;
    logic [DATA_W-1:0] grp0;
    logic [DATA_W-1:0] grp1;
    prio_t             prio0;
    prio_t             prio1;
    prio_t             sel;
    logic              sel_grp;
    logic [DATA_W-1:0] vec;

    assign act  = pend_q & mask_q;
    assign grp0 = act & ~route_q;
    assign grp1 = act & route_q;

    icf3z_intc_prio u_prio0 (
        .req   (grp0),
        .res_c (prio0)
    );

    icf3z_intc_prio u_prio1 (
        .req   (grp1),
        .res_c (prio1)
    );

    assign sel_grp = ~prio0.valid;
    assign sel     = prio0.valid ? prio0 : prio1;
    assign vec     = make_vec(sel, sel_grp);

    // Pending update: in edge mode a set beats any clear in the same cycle.
    logic [DATA_W-1:0] edge_set;
    logic [DATA_W-1:0] sw_set;
    logic [DATA_W-1:0] w1c;
    logic [DATA_W-1:0] ack_clr;
    logic [DATA_W-1:0] edge_next;
    logic [DATA_W-1:0] pend_d;

    assign edge_set  = src & ~prev_q;
    assign sw_set    = (wr_en && ofs == OFS_SWSET) ? xOUTPORT_P : '0;
    assign w1c       = (wr_en && ofs == OFS_PEND)  ? xOUTPORT_P : '0;
    assign ack_clr   = (vec_rd && sel.valid) ? DATA_W'(8'd1 << sel.idx) : '0;
    assign edge_next = (pend_q & ~(w1c | ack_clr)) | edge_set | sw_set;
    assign pend_d    = SRC_MASK & ((edge_q & edge_next) | (~edge_q & src));

    logic [DATA_W-1:0] rd_mux;

    always_comb begin
        rd_mux = '0;
        case (ofs)
            OFS_PEND:  rd_mux = pend_q;
            OFS_MASK:  rd_mux = mask_q;
            OFS_ROUTE: rd_mux = route_q;
            OFS_EDGE:  rd_mux = edge_q;
            OFS_VEC:   rd_mux = vec;
            default:   rd_mux = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (xRESET_P) begin
            pend_q   <= '0;
            mask_q   <= '0;
            route_q  <= '0;
            edge_q   <= '0;
            prev_q   <= '0;
            xRDATA_P <= '0;
            xHIT_P   <= 1'b0;
            xINT0_P  <= 1'b0;
            xINT1_P  <= 1'b0;
        end else begin
            pend_q <= pend_d;
            prev_q <= src;

            if (wr_en && ofs == OFS_MASK) begin
                mask_q <= xOUTPORT_P & SRC_MASK;
            end
            if (wr_en && ofs == OFS_ROUTE) begin
                route_q <= xOUTPORT_P & SRC_MASK;
            end
            if (wr_en && ofs == OFS_EDGE) begin
                edge_q <= xOUTPORT_P & SRC_MASK;
            end

            xRDATA_P <= in_range ? rd_mux : '0;
            xHIT_P   <= in_range;
            xINT0_P  <= |grp0;
            xINT1_P  <= |grp1;
        end
    end

endmodule

// File: tb/tb_icf3z_intc.sv
// Scoreboard bench for icf3z_intc: stimulus queues expectations, a monitor
// compares the registered outputs one clock after each request.
module tb_icf3z_intc;

    localparam logic [7:0] BASE = 8'hE0;

    localparam logic [2:0] O_PEND  = 3'd0;
    localparam logic [2:0] O_MASK  = 3'd1;
    localparam logic [2:0] O_ROUTE = 3'd2;
    localparam logic [2:0] O_EDGE  = 3'd3;
    localparam logic [2:0] O_SWSET = 3'd5;

    logic       CLK;
    logic       xRESET_P;
    logic [7:0] xSRC_P;
    logic [7:0] xPORTID_P;
    logic [7:0] xOUTPORT_P;
    logic       xWSTROBE_P;
    logic       xRSTROBE_P;
    logic [7:0] xRDATA_P;
    logic       xHIT_P;
    logic       xINT0_P;
    logic       xINT1_P;

    icf3z_intc #(
        .BASE (BASE),
        .NSRC (8)
    ) dut (
        .CLK        (CLK),
        .xRESET_P   (xRESET_P),
        .xSRC_P     (xSRC_P),
        .xPORTID_P  (xPORTID_P),
        .xOUTPORT_P (xOUTPORT_P),
        .xWSTROBE_P (xWSTROBE_P),
        .xRSTROBE_P (xRSTROBE_P),
        .xRDATA_P   (xRDATA_P),
        .xHIT_P     (xHIT_P),
        .xINT0_P    (xINT0_P),
        .xINT1_P    (xINT1_P)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct packed {
        logic       is_int;
        logic [7:0] data;
        logic       hit;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    issue_cnt = 0;
    int    due_cnt   = 0;
    int    n_chk     = 0;
    int    n_pass    = 0;

    // Expectations pushed during a cycle fall due right after that cycle's edge.
    always @(posedge CLK) due_cnt <= issue_cnt;

    always @(negedge CLK) begin
        exp_t  e;
        string nm;
        logic  ok;
        for (int n = 0; n < due_cnt; n++) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                $display("FAIL scoreboard_underflow: got empty queue, want an entry");
            end else begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                if (e.is_int)
                    ok = ({xINT1_P, xINT0_P} == e.data[1:0]);
                else
                    ok = (xRDATA_P == e.data) && (xHIT_P == e.hit);
                if (ok) begin
                    n_pass++;
                end else if (e.is_int) begin
                    $display("FAIL %s: got int1=%0b int0=%0b, want int1=%0b int0=%0b",
                             nm, xINT1_P, xINT0_P, e.data[1], e.data[0]);
                end else begin
                    $display("FAIL %s: got data=%02h hit=%0b, want data=%02h hit=%0b",
                             nm, xRDATA_P, xHIT_P, e.data, e.hit);
                end
            end
        end
    end

    task automatic push(input logic is_int, input logic [7:0] d, input logic h, input string nm);
        exp_t t;
        t.is_int = is_int;
        t.data   = d;
        t.hit    = h;
        exp_q.push_back(t);
        name_q.push_back(nm);
        issue_cnt++;
    endtask

    task automatic cyc();
        @(negedge CLK);
        issue_cnt  = 0;
        xWSTROBE_P = 1'b0;
        xRSTROBE_P = 1'b0;
        xPORTID_P  = 8'h00;
        xOUTPORT_P = 8'h00;
    endtask

    task automatic wr_addr(input logic [7:0] addr, input logic [7:0] d);
        cyc();
        xPORTID_P  = addr;
        xOUTPORT_P = d;
        xWSTROBE_P = 1'b1;
    endtask

    task automatic wr(input logic [2:0] o, input logic [7:0] d);
        wr_addr(BASE + 8'(o), d);
    endtask

    task automatic rd(input logic [7:0] addr, input logic strobe,
                      input logic [7:0] d, input logic h, input string nm);
        cyc();
        xPORTID_P  = addr;
        xRSTROBE_P = strobe;
        push(1'b0, d, h, nm);
    endtask

    task automatic chk_int(input logic i0, input logic i1, input string nm);
        push(1'b1, {6'b0, i1, i0}, 1'b0, nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        xRESET_P   = 1'b1;
        xSRC_P     = 8'h00;
        xPORTID_P  = 8'h00;
        xOUTPORT_P = 8'h00;
        xWSTROBE_P = 1'b0;
        xRSTROBE_P = 1'b0;

        // Writes while reset is held are lost
        wr(O_MASK, 8'hFF);
        wr(O_EDGE, 8'hFF);
        wr(O_SWSET, 8'hFF);
        cyc();
        xRESET_P = 1'b0;
        chk_int(1'b0, 1'b0, "rst_int_a");
        cyc();
        chk_int(1'b0, 1'b0, "rst_int_b");
        rd(8'hE0, 1'b0, 8'h00, 1'b1, "rst_pend");
        rd(8'hE1, 1'b0, 8'h00, 1'b1, "rst_mask");
        rd(8'hE2, 1'b0, 8'h00, 1'b1, "rst_route");
        rd(8'hE3, 1'b0, 8'h00, 1'b1, "rst_edge");
        rd(8'hE4, 1'b0, 8'h00, 1'b1, "rst_vec");

        // Edge path
        wr(O_EDGE, 8'hFF);
        wr(O_MASK, 8'h01);
        rd(8'hE3, 1'b0, 8'hFF, 1'b1, "edge_readback");
        cyc();
        xSRC_P[0] = 1'b1;
        chk_int(1'b0, 1'b0, "edge_int_pre");
        rd(8'hE0, 1'b0, 8'h01, 1'b1, "edge_pend");
        chk_int(1'b1, 1'b0, "edge_int0_up");
        rd(8'hE4, 1'b1, 8'h80, 1'b1, "edge_vec");
        rd(8'hE0, 1'b0, 8'h00, 1'b1, "edge_pend_acked");
        chk_int(1'b0, 1'b0, "edge_int0_down");
        cyc();
        xSRC_P = 8'h00;

        // Routing and priority
        wr(O_ROUTE, 8'h0C);
        wr(O_MASK, 8'hFF);
        wr(O_SWSET, 8'h0C);
        rd(8'hE4, 1'b0, 8'hC2, 1'b1, "route_vec_grp1");
        chk_int(1'b0, 1'b1, "route_int1");
        wr(O_SWSET, 8'h20);
        rd(8'hE4, 1'b1, 8'h85, 1'b1, "prio_grp0_wins");
        chk_int(1'b1, 1'b1, "route_int_both");
        rd(8'hE4, 1'b1, 8'hC2, 1'b1, "vec_ack_2");
        rd(8'hE4, 1'b1, 8'hC3, 1'b1, "vec_ack_3");
        rd(8'hE0, 1'b0, 8'h00, 1'b1, "pend_after_acks");
        chk_int(1'b0, 1'b0, "ints_idle");

        // Set beats clear
        wr(O_SWSET, 8'h08);
        wr(O_PEND, 8'h08);
        xSRC_P[3] = 1'b1;
        rd(8'hE0, 1'b0, 8'h08, 1'b1, "set_beats_clear");
        wr(O_PEND, 8'h08);
        rd(8'hE0, 1'b0, 8'h00, 1'b1, "w1c_clears");
        cyc();
        xSRC_P = 8'h00;

        // Level mode
        wr(O_EDGE, 8'h00);
        wr(O_ROUTE, 8'h00);
        wr(O_MASK, 8'h02);
        cyc();
        xSRC_P[1] = 1'b1;
        rd(8'hE0, 1'b0, 8'h02, 1'b1, "level_pend");
        chk_int(1'b1, 1'b0, "level_int0");
        wr(O_PEND, 8'h02);
        rd(8'hE0, 1'b0, 8'h02, 1'b1, "level_w1c_ignored");
        cyc();
        xSRC_P[1] = 1'b0;
        chk_int(1'b1, 1'b0, "level_int0_hold");
        cyc();
        chk_int(1'b0, 1'b0, "level_int0_drop");
        wr(O_SWSET, 8'h02);
        rd(8'hE0, 1'b0, 8'h00, 1'b1, "level_swset_ignored");

        // Address decode
        rd(8'hE6, 1'b0, 8'h00, 1'b1, "ofs6");
        rd(8'hE7, 1'b0, 8'h00, 1'b1, "ofs7");
        rd(8'hE8, 1'b0, 8'h00, 1'b0, "out_of_range");
        wr(O_MASK, 8'h5A);
        wr_addr(8'hE9, 8'hFF);
        rd(8'hE1, 1'b0, 8'h5A, 1'b1, "mask_after_oor_write");

        // Reset mid-operation drops the concurrent write
        cyc();
        xRESET_P   = 1'b1;
        xPORTID_P  = 8'hE1;
        xOUTPORT_P = 8'h33;
        xWSTROBE_P = 1'b1;
        cyc();
        xRESET_P = 1'b0;
        rd(8'hE1, 1'b0, 8'h00, 1'b1, "mask_after_reset");

        cyc();
        cyc();
        @(posedge CLK);
        #1;
        if (exp_q.size() != 0) begin
            n_chk++;
            $display("FAIL scoreboard_leftover: got %0d entries, want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
